// File: rtl/mem_access_if.sv
// Request, write-data, read-data and memory-port signals of the burst memory access unit.
// The slave modport is the unit; the master modport is the requester and memory side.
interface mem_access_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_len;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic        done;
  logic        err;
  logic [31:0] mem_ain;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [31:0] mem_dout;

  modport slave (
    input  req_valid, req_write, req_addr, req_len, wr_data, wr_valid, mem_dout,
    output req_ready, wr_ready, rd_data, rd_valid, rd_last, done, err,
           mem_ain, mem_din, mem_we
  );

  modport master (
    output req_valid, req_write, req_addr, req_len, wr_data, wr_valid, mem_dout,
    input  req_ready, wr_ready, rd_data, rd_valid, rd_last, done, err,
           mem_ain, mem_din, mem_we
  );
endinterface

// File: rtl/mem_access_unit.sv
// Burst read/write engine (1..8 words) in front of a single-port word memory.
// Out-of-range bursts are rejected with err and never touch the memory.
module mem_access_unit #(
  parameter int MEM_DEPTH = 206
) (
  input logic         clk,
  input logic         reset,
  mem_access_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_WAIT, WR_PUSH, FIN} state_t;

  state_t      state_reg;
  logic [31:0] base_reg;
  logic [2:0]  len_reg;
  logic [2:0]  count_reg;
  logic        reject_reg;

  // Last touched address in 33 bits so a start near 2^32 cannot wrap into range.
  logic [32:0] end_addr;
  logic        in_range;
  assign end_addr = {1'b0, bus.req_addr} + {30'd0, bus.req_len};
  assign in_range = (end_addr <= 33'(MEM_DEPTH - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      base_reg      <= '0;
      len_reg       <= '0;
      count_reg     <= '0;
      reject_reg    <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.wr_ready  <= 1'b0;
      bus.rd_data   <= '0;
      bus.rd_valid  <= 1'b0;
      bus.rd_last   <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.mem_ain   <= '0;
      bus.mem_din   <= '0;
      bus.mem_we    <= 1'b0;
    end else begin
      // Pulse outputs fall back to zero unless a state re-asserts them.
      bus.rd_valid <= 1'b0;
      bus.rd_last  <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.mem_we   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            base_reg      <= bus.req_addr;
            len_reg       <= bus.req_len;
            count_reg     <= '0;
            bus.req_ready <= 1'b0;
            if (!in_range) begin
              reject_reg <= 1'b1;
              state_reg  <= FIN;
            end else begin
              reject_reg <= 1'b0;
              if (bus.req_write) begin
                bus.wr_ready <= 1'b1;
                state_reg    <= WR_WAIT;
              end else begin
                state_reg <= RD_ADDR;
              end
            end
          end
        end
        RD_ADDR: begin
          bus.mem_ain <= base_reg + {29'd0, count_reg};
          state_reg   <= RD_DATA;
        end
        RD_DATA: begin
          bus.rd_data  <= bus.mem_dout;
          bus.rd_valid <= 1'b1;
          if (count_reg == len_reg) begin
            bus.rd_last <= 1'b1;
            state_reg   <= FIN;
          end else begin
            count_reg <= count_reg + 3'd1;
            state_reg <= RD_ADDR;
          end
        end
        WR_WAIT: begin
          if (bus.wr_valid) begin
            bus.mem_ain  <= base_reg + {29'd0, count_reg};
            bus.mem_din  <= bus.wr_data;
            bus.mem_we   <= 1'b1;
            bus.wr_ready <= 1'b0;
            state_reg    <= WR_PUSH;
          end
        end
        WR_PUSH: begin
          if (count_reg == len_reg) begin
            state_reg <= FIN;
          end else begin
            count_reg    <= count_reg + 3'd1;
            bus.wr_ready <= 1'b1;
            state_reg    <= WR_WAIT;
          end
        end
        FIN: begin
          bus.done      <= 1'b1;
          bus.err       <= reject_reg;
          bus.req_ready <= 1'b1;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a word memory, a shadow reference memory and
// per-scenario tasks that predict every cycle of a burst from the protocol timing.
module tb_mem_access_unit;
  localparam int DEPTH = 206;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_access_if bus();

  mem_access_unit #(.MEM_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [31:0] mem      [DEPTH];
  logic [31:0] init_mem [DEPTH];
  logic [31:0] ref_mem  [DEPTH];
  logic [31:0] wdata    [8];
  logic        load_all = 1'b0;
  int errors = 0;
  int checks = 0;

  // Attached memory: synchronous write, combinational read of the current address.
  always @(posedge clk) begin
    if (load_all) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_mem[i];
    end else if (bus.mem_we && bus.mem_ain < DEPTH) begin
      mem[bus.mem_ain[7:0]] <= bus.mem_din;
    end
  end
  assign bus.mem_dout = (bus.mem_ain < DEPTH) ? mem[bus.mem_ain[7:0]] : 32'hBAD0_BAD0;

  // Read burst: word i appears 2+2i edges after acceptance, done one edge after the last
  // word; a rejected request shows done/err one edge after acceptance.
  task automatic run_read(input logic [31:0] addr, input logic [2:0] len,
                          input int poke_k, input string name);
    logic [32:0] last_addr;
    logic        ok;
    logic        rv;
    logic [31:0] ain0;
    logic [5:0]  exp_f, obs_f;
    int ln, done_k, wi, ai;
    ln = int'(len);
    last_addr = {1'b0, addr} + 33'(len);
    ok = (last_addr <= 33'(DEPTH - 1));
    done_k = ok ? 2 * ln + 3 : 1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready before request: got %b want 1", name, bus.req_ready);
    end
    ain0 = bus.mem_ain;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = addr; bus.req_len = len;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 0; k <= done_k + 1; k++) begin
      if (k > 0) @(negedge clk);
      wi = (k - 2) / 2;
      rv = ok && k >= 2 && (k % 2 == 0) && wi <= ln;
      exp_f = {rv, rv && wi == ln, k == done_k, !ok && k == done_k, k >= done_k, 1'b0};
      obs_f = {bus.rd_valid, bus.rd_last, bus.done, bus.err, bus.req_ready, bus.mem_we};
      checks++;
      if (obs_f !== exp_f) begin
        errors++;
        $display("FAIL %s flags k=%0d rv,last,done,err,rdy,we: got %b want %b", name, k, obs_f, exp_f);
      end
      if (rv) begin
        ai = int'(addr) + wi;
        checks++;
        if (bus.rd_data !== ref_mem[ai] || bus.mem_ain !== 32'(ai)) begin
          errors++;
          $display("FAIL %s word %0d: got data %h addr %0d want data %h addr %0d",
                   name, wi, bus.rd_data, bus.mem_ain, ref_mem[ai], ai);
        end
      end
      if (!ok) begin
        checks++;
        if (bus.mem_ain !== ain0) begin
          errors++;
          $display("FAIL %s rejected mem_ain moved: got %h want %h", name, bus.mem_ain, ain0);
        end
      end
      if (k == poke_k) begin
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = '0; bus.req_len = '0;
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    $display("read  %-12s addr=%0d len=%0d ok=%0b", name, addr, len, ok);
  endtask

  // Write burst: each accepted word gives one mem_we cycle, then one cycle with wr_ready
  // low; done follows two edges after the last mem_we.
  task automatic run_write(input logic [31:0] addr, input logic [2:0] len, input int stall_at,
                           input int stall_n, input bit gaps, input int abort_at, input string name);
    logic [32:0] last_addr;
    logic        ok, waiting, exp_we, finished, stall_now;
    logic [31:0] ain0, we_addr, we_data;
    logic [4:0]  exp_f, obs_f;
    int ln, done_k, idx, stall_left;
    ln = int'(len);
    last_addr = {1'b0, addr} + 33'(len);
    ok = (last_addr <= 33'(DEPTH - 1));
    done_k = ok ? -1 : 1;
    waiting = ok; exp_we = 1'b0; finished = 1'b0; idx = 0; stall_left = stall_n;
    we_addr = '0; we_data = '0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready before request: got %b want 1", name, bus.req_ready);
    end
    ain0 = bus.mem_ain;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = addr; bus.req_len = len;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (k > 0) @(negedge clk);
      exp_f = {waiting, exp_we, done_k >= 0 && k == done_k, !ok && k == done_k,
               done_k >= 0 && k >= done_k};
      obs_f = {bus.wr_ready, bus.mem_we, bus.done, bus.err, bus.req_ready};
      checks++;
      if (obs_f !== exp_f) begin
        errors++;
        $display("FAIL %s flags k=%0d wrdy,we,done,err,rdy: got %b want %b", name, k, obs_f, exp_f);
      end
      if (exp_we) begin
        checks++;
        if (bus.mem_ain !== we_addr || bus.mem_din !== we_data) begin
          errors++;
          $display("FAIL %s write port: got addr %0d data %h want addr %0d data %h",
                   name, bus.mem_ain, bus.mem_din, we_addr, we_data);
        end
      end
      if (!ok) begin
        checks++;
        if (bus.mem_ain !== ain0) begin
          errors++;
          $display("FAIL %s rejected mem_ain moved: got %h want %h", name, bus.mem_ain, ain0);
        end
      end
      if (abort_at > 0 && exp_we && idx == abort_at) begin
        bus.wr_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int j = 0; j < 6; j++) begin
          obs_f = {bus.mem_we, bus.done, bus.err, bus.wr_ready, bus.req_ready};
          checks++;
          if (obs_f !== 5'b00001) begin
            errors++;
            $display("FAIL %s after abort j=%0d we,done,err,wrdy,rdy: got %b want 00001", name, j, obs_f);
          end
          @(negedge clk);
        end
        finished = 1'b1;
        break;
      end
      if (done_k >= 0 && k == done_k + 1) begin
        finished = 1'b1;
        break;
      end
      stall_now = waiting && idx == stall_at && stall_left > 0;
      if (stall_now) stall_left--;
      bus.wr_valid = ok && idx <= ln && !stall_now && !(gaps && $urandom_range(0, 3) == 0);
      bus.wr_data  = (idx <= ln) ? wdata[idx] : 32'h0;
      if (exp_we) begin
        exp_we = 1'b0;
        if (idx <= ln) waiting = 1'b1;
        else done_k = k + 2;
      end else if (waiting && bus.wr_valid) begin
        exp_we = 1'b1;
        waiting = 1'b0;
        we_addr = addr + 32'(idx);
        we_data = wdata[idx];
        ref_mem[we_addr[7:0]] = we_data;
        idx++;
      end
    end
    bus.wr_valid = 1'b0;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout waiting for done", name);
    end
    if (ok) begin
      @(negedge clk);
      for (int i = 0; i <= ln; i++) begin
        checks++;
        if (mem[addr[7:0] + 8'(i)] !== ref_mem[addr[7:0] + 8'(i)]) begin
          errors++;
          $display("FAIL %s memory[%0d]: got %h want %h", name, int'(addr) + i,
                   mem[addr[7:0] + 8'(i)], ref_mem[addr[7:0] + 8'(i)]);
        end
      end
    end
    $display("write %-12s addr=%0d len=%0d ok=%0b words=%0d", name, addr, len, ok, idx);
  endtask

  task automatic test_reset();
    logic [6:0] f;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    f = {bus.req_ready, bus.wr_ready, bus.mem_we, bus.rd_valid, bus.rd_last, bus.done, bus.err};
    checks++;
    if (f !== 7'b1000000) begin
      errors++;
      $display("FAIL reset flags rdy,wrdy,we,rv,last,done,err: got %b want 1000000", f);
    end
    checks++;
    if ({bus.mem_ain, bus.mem_din, bus.rd_data} !== 96'h0) begin
      errors++;
      $display("FAIL reset data regs: got ain %h din %h rd %h want 0", bus.mem_ain, bus.mem_din, bus.rd_data);
    end
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) init_mem[i] = $urandom;
    init_mem[5] = 32'hDEADBEEF;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_mem[i];
    load_all = 1'b1;
    @(negedge clk);
    load_all = 1'b0;
    $display("reset done");
  endtask

  task automatic test_single_read();
    run_read(32'd5, 3'd0, -1, "single_rd");
  endtask

  task automatic test_burst_write_read();
    for (int i = 0; i < 8; i++) wdata[i] = 32'h100 + 32'(i);
    run_write(32'd10, 3'd7, -1, 0, 1'b0, -1, "burst_wr");
    run_read(32'd10, 3'd7, -1, "burst_rd");
  endtask

  task automatic test_boundary();
    run_read(32'd198, 3'd7, -1, "edge_ok");
    run_read(32'd199, 3'd7, -1, "edge_over");
    run_read(32'hFFFF_FFFF, 3'd1, -1, "wrap");
    run_write(32'd205, 3'd1, -1, 0, 1'b0, -1, "wr_over");
    wdata[0] = 32'hA5A5_0001;
    run_write(32'd205, 3'd0, -1, 0, 1'b0, -1, "wr_last");
  endtask

  task automatic test_write_stall();
    for (int i = 0; i < 8; i++) wdata[i] = $urandom;
    run_write(32'd40, 3'd7, 3, 10, 1'b0, -1, "stall_wr");
    run_read(32'd40, 3'd7, -1, "stall_rd");
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 8; i++) wdata[i] = $urandom;
    run_write(32'd60, 3'd7, -1, 0, 1'b0, 3, "abort_wr");
    run_read(32'd60, 3'd7, -1, "abort_rd");
  endtask

  task automatic test_busy_reject();
    run_read(32'd100, 3'd5, 5, "busy_rd");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [2:0]  l;
    for (int n = 0; n < 24; n++) begin
      a = 32'($urandom_range(0, DEPTH + 3));
      l = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 8; i++) wdata[i] = $urandom;
        run_write(a, l, -1, 0, 1'b1, -1, "rand_wr");
      end else begin
        run_read(a, l, -1, "rand_rd");
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0;
    test_reset();
    test_single_read();
    test_burst_write_read();
    test_boundary();
    test_write_stall();
    test_reset_mid_burst();
    test_busy_reject();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
